conv_window_feeder: RTL

- Streams convolution operands into one `pe` instance: for each output pixel, K*K (pixel, weight) pairs with `inmap_vld`/`weight_vld`, plus a constant bias.
- Holds one input feature map and one KxK kernel in local synchronous-read RAMs, loaded through a simple write port.
- Transmit side of the PE operand interface. Sits between the layer controller (start/hold) and the PE.

---
 rtl/conv_window_feeder_if.sv | 33 +++
 rtl/conv_window_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder_if.sv
// Operand/load bundle between the layer controller, the window feeder and the PE.
// The master side drives loads, start and hold; the slave side (the feeder) drives the PE operands.
interface conv_window_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              ld_en;
    logic [1:0]        ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] inmap;
    logic [DATA_W-1:0] weight;
    logic              inmap_vld;
    logic              weight_vld;
    logic [DATA_W-1:0] bias;
    logic              win_last;
    logic [7:0]        out_row;
    logic [7:0]        out_col;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, hold,
        input  busy, done, inmap, weight, inmap_vld, weight_vld, bias, win_last, out_row, out_col
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, hold,
        output busy, done, inmap, weight, inmap_vld, weight_vld, bias, win_last, out_row, out_col
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Streams KxK (pixel, weight) operand pairs per output pixel from local RAMs to one PE.
// Two-stage pipeline: RAM read register, then the gated output register.
module conv_window_feeder #(
    parameter int K      = 5,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_feeder_if.slave  bus
);
    localparam int OW   = IMG_W - K + 1;
    localparam int OH   = IMG_H - K + 1;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int NTAP = K * K;
    localparam int PA_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int WA_W = (NTAP > 1) ? $clog2(NTAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_drain_cnt;

    logic [7:0] r_kj, r_ki, r_c, r_r;

    logic [DATA_W-1:0] r_pix_mem [0:NPIX-1];
    logic [DATA_W-1:0] r_wgt_mem [0:NTAP-1];
    logic [DATA_W-1:0] r_pix_q, r_wgt_q;
    logic [DATA_W-1:0] r_bias;

    logic       r_s1_vld, r_s1_last, r_s1_done;
    logic [7:0] r_s1_row, r_s1_col;

    logic              r_vld, r_last, r_done;
    logic [DATA_W-1:0] r_inmap, r_weight;
    logic [7:0]        r_row, r_col;

    logic              w_idle, w_issue;
    logic              w_kj_wrap, w_ki_wrap, w_c_wrap, w_r_wrap, w_final;
    logic [7:0]        w_row_sum, w_col_sum;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [WA_W-1:0]   w_wgt_addr;
    logic              w_ld_ok, w_pix_we, w_wgt_we, w_bias_we;
    logic              w_pix_fwd, w_wgt_fwd;

    assign w_idle = (r_state == S_IDLE);
    // Beat 0 is issued in the start cycle itself so it surfaces two cycles after start.
    assign w_issue = (w_idle && bus.start) || ((r_state == S_STREAM) && !bus.hold);

    assign w_kj_wrap = (r_kj == 8'(K - 1));
    assign w_ki_wrap = (r_ki == 8'(K - 1));
    assign w_c_wrap  = (r_c  == 8'(OW - 1));
    assign w_r_wrap  = (r_r  == 8'(OH - 1));
    assign w_final   = w_kj_wrap && w_ki_wrap && w_c_wrap && w_r_wrap;

    assign w_row_sum  = r_r + r_ki;
    assign w_col_sum  = r_c + r_kj;
    assign w_pix_addr = ADDR_W'(w_row_sum) * ADDR_W'(IMG_W) + ADDR_W'(w_col_sum);
    assign w_wgt_addr = WA_W'(r_ki) * WA_W'(K) + WA_W'(r_kj);

    assign w_ld_ok   = bus.ld_en && w_idle;
    assign w_pix_we  = w_ld_ok && (bus.ld_sel == 2'd0) && ({1'b0, bus.ld_addr} < (ADDR_W + 1)'(NPIX));
    assign w_wgt_we  = w_ld_ok && (bus.ld_sel == 2'd1) && ({1'b0, bus.ld_addr} < (ADDR_W + 1)'(NTAP));
    assign w_bias_we = w_ld_ok && (bus.ld_sel == 2'd2);

    // A load coinciding with start must be seen by beat 0, so bypass the RAM on an address hit.
    assign w_pix_fwd = w_pix_we && (bus.ld_addr[PA_W-1:0] == w_pix_addr[PA_W-1:0]);
    assign w_wgt_fwd = w_wgt_we && (bus.ld_addr[WA_W-1:0] == w_wgt_addr);

    always_ff @(posedge clk) begin
        if (w_pix_we) begin
            r_pix_mem[bus.ld_addr[PA_W-1:0]] <= bus.ld_data;
        end
        r_pix_q <= w_pix_fwd ? bus.ld_data : r_pix_mem[w_pix_addr[PA_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (w_wgt_we) begin
            r_wgt_mem[bus.ld_addr[WA_W-1:0]] <= bus.ld_data;
        end
        r_wgt_q <= w_wgt_fwd ? bus.ld_data : r_wgt_mem[w_wgt_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bias <= '0;
        end else if (w_bias_we) begin
            r_bias <= bus.ld_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = w_final ? S_DRAIN : S_STREAM;
            S_STREAM: if (w_issue && w_final) w_state_next = S_DRAIN;
            S_DRAIN:  if (r_drain_cnt) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // Tap counters kj -> ki -> c -> r; the final beat wraps all four back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kj <= '0;
            r_ki <= '0;
            r_c  <= '0;
            r_r  <= '0;
        end else if (w_issue) begin
            if (w_kj_wrap) begin
                r_kj <= '0;
                if (w_ki_wrap) begin
                    r_ki <= '0;
                    if (w_c_wrap) begin
                        r_c <= '0;
                        r_r <= w_r_wrap ? '0 : r_r + 8'd1;
                    end else begin
                        r_c <= r_c + 8'd1;
                    end
                end else begin
                    r_ki <= r_ki + 8'd1;
                end
            end else begin
                r_kj <= r_kj + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_done <= 1'b0;
            r_s1_row  <= '0;
            r_s1_col  <= '0;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_inmap   <= '0;
            r_weight  <= '0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_s1_vld  <= w_issue;
            r_s1_last <= w_kj_wrap && w_ki_wrap;
            r_s1_done <= w_final;
            r_s1_row  <= r_r;
            r_s1_col  <= r_c;
            r_vld     <= r_s1_vld;
            r_last    <= r_s1_vld && r_s1_last;
            r_done    <= r_s1_vld && r_s1_done;
            r_inmap   <= r_s1_vld ? r_pix_q : '0;
            r_weight  <= r_s1_vld ? r_wgt_q : '0;
            if (r_s1_vld) begin
                r_row <= r_s1_row;
                r_col <= r_s1_col;
            end
        end
    end

    assign bus.busy       = !w_idle;
    assign bus.done       = r_done;
    assign bus.inmap      = r_inmap;
    assign bus.weight     = r_weight;
    assign bus.inmap_vld  = r_vld;
    assign bus.weight_vld = r_vld;
    assign bus.bias       = r_bias;
    assign bus.win_last   = r_last;
    assign bus.out_row    = r_row;
    assign bus.out_col    = r_col;
endmodule
